// File: rtl/nic_flt_log_pkg.sv
// Shared constants, FSM states and helpers for the NIC fault logger.
// Optional alert output is enabled by defining NIC_FLT_LOG_ALERT_EN.
package nic_flt_log_pkg;

  localparam int FLT_AUX_SEQ_NIC0  = 0;
  localparam int FLT_P12V_SEQ_NIC0 = 1;
  localparam int FLT_AUX_SEQ_NIC1  = 2;
  localparam int FLT_P12V_SEQ_NIC1 = 3;
  localparam int FLT_AUX_RT_NIC0   = 4;
  localparam int FLT_P12V_RT_NIC0  = 5;
  localparam int FLT_AUX_RT_NIC1   = 6;
  localparam int FLT_P12V_RT_NIC1  = 7;

  localparam logic [1:0] ADDR_STICKY = 2'd0;
  localparam logic [1:0] ADDR_FIRST  = 2'd1;
  localparam logic [1:0] ADDR_SNAP   = 2'd2;
  localparam logic [1:0] ADDR_COUNT  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_LATCHED
  } fltState_t;

  function automatic logic [3:0] popCount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

  // Highest-to-lowest scan so the lowest set bit wins.
  function automatic logic [2:0] lowestIdx(input logic [7:0] v);
    logic [2:0] idx;
    idx = '0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) begin
        idx = 3'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/nic_flt_debounce.sv
// Per-flag debounce: saturating high-run counter with level and edge outputs.
// Part of the NIC fault logger (alert option: NIC_FLT_LOG_ALERT_EN).
module nic_flt_debounce #(
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic iClk,
  input  logic iRst,
  input  logic iFlt,
  output logic oQual,
  output logic oRise
);

  localparam logic [3:0] LIM = 4'(DEBOUNCE_CYC);

  logic [3:0] cnt;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      cnt <= '0;
    end else if (!iFlt) begin
      cnt <= '0;
    end else if (cnt != LIM) begin
      cnt <= cnt + 4'd1;
    end
  end

  // Qualification is reported in the cycle the counter reaches the limit.
  assign oRise = iFlt & (cnt == LIM - 4'd1);
  assign oQual = iFlt & (oRise | (cnt == LIM));

endmodule

// File: rtl/ocp3_nic_fault_logger.sv
// NIC fault logger: sticky faults, first-fault capture, event count, read port.
// Define NIC_FLT_LOG_ALERT_EN to drive oFLT_ALERT_N from the sticky bits.
module ocp3_nic_fault_logger
  import nic_flt_log_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 4,
  parameter int CNT_W        = 8
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic [7:0] iFlt,
  input  logic [7:0] iNICx_FSM_curr,
  input  logic       iClr,
  input  logic       iRdEn,
  input  logic [1:0] iRdAddr,
  output logic [7:0] oRdData,
  output logic       oRdValid,
  output logic [7:0] oFltSticky,
  output logic       oFirstFltVld,
  output logic [2:0] oFirstFltIdx,
  output logic       oFLT_ALERT_N
);

  localparam int SW = CNT_W + 4;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [7:0] qual;
  logic [7:0] rise;
  logic [7:0] evt;

  for (genvar i = 0; i < 8; i++) begin : gDeb
    nic_flt_debounce #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) uDeb (
      .iClk (iClk),
      .iRst (iRst),
      .iFlt (iFlt[i]),
      .oQual(qual[i]),
      .oRise(rise[i])
    );
  end

  assign evt = rise & qual;

  fltState_t        state;
  fltState_t        stateNxt;
  logic             latch;
  logic [7:0]       snap;
  logic [CNT_W-1:0] evtCnt;
  logic [CNT_W-1:0] cntBase;
  logic [CNT_W-1:0] cntNxt;
  logic [SW-1:0]    cntSum;
  logic [7:0]       stickyBase;
  logic [7:0]       cnt8;
  logic [CNT_W+7:0] cntExt;

  always_comb begin
    stateNxt = state;
    latch    = 1'b0;
    unique case (state)
      ST_IDLE: stateNxt = ST_ARMED;
      ST_ARMED: begin
        if (|evt) begin
          stateNxt = ST_LATCHED;
          latch    = 1'b1;
        end
      end
      ST_LATCHED: begin
        // A fault arriving with the clear becomes the new first fault.
        if (iClr) begin
          if (|evt) begin
            latch = 1'b1;
          end else begin
            stateNxt = ST_ARMED;
          end
        end
      end
      default: stateNxt = ST_IDLE;
    endcase
  end

  always_comb begin
    stickyBase = iClr ? 8'h00 : oFltSticky;
    cntBase    = iClr ? '0 : evtCnt;
    cntSum     = SW'(cntBase) + SW'(popCount8(evt));
    cntNxt     = (cntSum > SW'(CNT_MAX)) ? CNT_MAX : cntSum[CNT_W-1:0];
    cntExt     = {8'h00, evtCnt};
    cnt8       = cntExt[7:0];
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state        <= ST_IDLE;
      oFltSticky   <= '0;
      evtCnt       <= '0;
      oFirstFltVld <= 1'b0;
      oFirstFltIdx <= '0;
      snap         <= '0;
    end else begin
      state      <= stateNxt;
      oFltSticky <= stickyBase | evt;
      evtCnt     <= cntNxt;
      if (latch) begin
        oFirstFltVld <= 1'b1;
        oFirstFltIdx <= lowestIdx(evt);
        snap         <= iNICx_FSM_curr;
      end else if (iClr) begin
        oFirstFltVld <= 1'b0;
        oFirstFltIdx <= '0;
        snap         <= '0;
      end
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      oRdValid <= 1'b0;
      oRdData  <= '0;
    end else begin
      oRdValid <= iRdEn;
      if (iRdEn) begin
        unique case (1'b1)
          (iRdAddr == ADDR_STICKY): oRdData <= oFltSticky;
          (iRdAddr == ADDR_FIRST):
            oRdData <= {oFirstFltVld, 4'b0000, oFirstFltIdx};
          (iRdAddr == ADDR_SNAP):   oRdData <= snap;
          (iRdAddr == ADDR_COUNT):  oRdData <= cnt8;
          default:                  oRdData <= '0;
        endcase
      end
    end
  end

`ifdef NIC_FLT_LOG_ALERT_EN
  logic alertN;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      alertN <= 1'b1;
    end else begin
      alertN <= ~(|oFltSticky);
    end
  end

  assign oFLT_ALERT_N = alertN;
`else
  assign oFLT_ALERT_N = 1'b1;
`endif

endmodule

// File: tb/tb_ocp3_nic_fault_logger.sv
// Randomized and directed bench for the NIC fault logger against a
// cycle-level behavioural model of the logging rules.
`timescale 1ns/1ps
module tb_ocp3_nic_fault_logger;

  localparam int DEB = 4;
  localparam int CW  = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] flt;
  logic [7:0] fsm;
  logic       clr;
  logic       rdEn;
  logic [1:0] rdAddr;
  logic [7:0] rdData;
  logic       rdValid;
  logic [7:0] sticky;
  logic       firstVld;
  logic [2:0] firstIdx;
  logic       alertN;

  always #250 clk = ~clk;

  ocp3_nic_fault_logger #(
    .DEBOUNCE_CYC(DEB),
    .CNT_W       (CW)
  ) dut (
    .iClk          (clk),
    .iRst          (rst),
    .iFlt          (flt),
    .iNICx_FSM_curr(fsm),
    .iClr          (clr),
    .iRdEn         (rdEn),
    .iRdAddr       (rdAddr),
    .oRdData       (rdData),
    .oRdValid      (rdValid),
    .oFltSticky    (sticky),
    .oFirstFltVld  (firstVld),
    .oFirstFltIdx  (firstIdx),
    .oFLT_ALERT_N  (alertN)
  );

  int nChecks = 0;
  int nErrors = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: run lengths, sticky set, first record, event total.
  int         run[8];
  logic [7:0] mSticky;
  int         mCount;
  bit         mVld;
  logic [2:0] mIdx;
  logic [7:0] mSnap;
  bit         mArmed;
  logic [7:0] mRdData;
  bit         mRdValid;
  bit         mAlertN;

  task automatic modelStep();
    logic [7:0] ev;
    if (rst) begin
      foreach (run[i]) run[i] = 0;
      mSticky = 0; mCount = 0; mVld = 0; mIdx = 0; mSnap = 0;
      mArmed = 0; mRdData = 0; mRdValid = 0; mAlertN = 1;
      return;
    end
    ev = 0;
    for (int i = 0; i < 8; i++) begin
      if (flt[i]) begin
        run[i]++;
        if (run[i] == DEB) ev[i] = 1'b1;
      end else begin
        run[i] = 0;
      end
    end
    mRdValid = rdEn;
    if (rdEn) begin
      case (rdAddr)
        2'd0: mRdData = mSticky;
        2'd1: mRdData = {mVld, 4'b0000, mIdx};
        2'd2: mRdData = mSnap;
        default: mRdData = 8'(mCount);
      endcase
    end
`ifdef NIC_FLT_LOG_ALERT_EN
    mAlertN = (mSticky == 0);
`else
    mAlertN = 1;
`endif
    if (clr) begin
      mSticky = 0; mCount = 0; mVld = 0; mIdx = 0; mSnap = 0;
    end
    mSticky |= ev;
    mCount += $countones(ev);
    if (mCount > CMAX) mCount = CMAX;
    if (ev != 0 && mArmed && !mVld) begin
      mVld = 1;
      mSnap = fsm;
      for (int i = 7; i >= 0; i--) if (ev[i]) mIdx = 3'(i);
    end
    mArmed = 1;
  endtask

  task automatic cycle();
    modelStep();
    @(posedge clk);
    #1;
    check("sticky", sticky, mSticky);
    check("firstVld", firstVld, mVld);
    check("firstIdx", firstIdx, mIdx);
    check("rdValid", rdValid, mRdValid);
    check("rdData", rdData, mRdData);
    check("alertN", alertN, mAlertN);
  endtask

  task automatic drv(input logic r, input logic [7:0] f, input logic c,
                     input logic re, input logic [1:0] a);
    rst = r; flt = f; clr = c; rdEn = re; rdAddr = a;
    cycle();
  endtask

  initial begin
    rst = 1; flt = 0; fsm = 0; clr = 0; rdEn = 0; rdAddr = 0;
    cycle();
    cycle();
    check("rstSticky", sticky, 8'h00);
    check("rstAlert", alertN, 1'b1);
    drv(0, 8'h00, 0, 0, 0);

    repeat (3) drv(0, 8'h01, 0, 0, 0);
    drv(0, 8'h00, 0, 1, 3);
    check("shortCount", rdData, 8'h00);
    check("shortSticky", sticky, 8'h00);

    fsm = 8'h53;
    repeat (10) drv(0, 8'h20, 0, 0, 0);
    check("t2Sticky", sticky, 8'h20);
    fsm = 8'h00;
    drv(0, 8'h00, 0, 1, 2);
    check("t2Snap", rdData, 8'h53);
    drv(0, 8'h00, 0, 1, 1);
    check("t2First", rdData, 8'h85);
    drv(0, 8'h00, 0, 1, 3);
    check("t2Count", rdData, 8'h01);

    drv(0, 8'h00, 1, 0, 0);
    repeat (5) drv(0, 8'h0A, 0, 0, 0);
    check("t3Sticky", sticky, 8'h0A);
    check("t3Idx", firstIdx, 3'd1);
    drv(0, 8'h0A, 0, 1, 3);
    check("t3Count", rdData, 8'h02);

    repeat (5) drv(0, 8'h8A, 0, 0, 0);
    check("t4Sticky", sticky, 8'h8A);
    drv(0, 8'h8A, 0, 1, 3);
    check("t4Valid", rdValid, 1'b1);
    check("t4Count", rdData, 8'h03);
    drv(0, 8'h8A, 0, 1, 1);
    check("t4First", rdData, 8'h81);

    repeat (3) drv(0, 8'h04, 0, 0, 0);
    drv(0, 8'h04, 1, 0, 0);
    check("clrEvtSticky", sticky, 8'h04);
    drv(0, 8'h00, 0, 1, 1);
    check("clrEvtFirst", rdData, 8'h82);
    drv(0, 8'h00, 0, 1, 3);
    check("clrEvtCount", rdData, 8'h01);

    for (int r = 0; r < 40; r++) begin
      fsm = 8'($urandom);
      repeat (5) drv(0, 8'hFF, 0, 0, 0);
      drv(0, 8'h00, 0, 0, 0);
    end
    drv(0, 8'h00, 0, 1, 3);
    check("satCount", rdData, 8'hFF);

    for (int n = 0; n < 2000; n++) begin
      logic [7:0] f;
      f = flt;
      for (int i = 0; i < 8; i++)
        if ($urandom_range(0, 5) == 0) f[i] = ~f[i];
      fsm = 8'($urandom);
      drv(($urandom_range(0, 499) == 0), f,
          ($urandom_range(0, 39) == 0), 1'($urandom),
          2'($urandom));
    end

    repeat (6) drv(0, 8'hFF, 0, 1, 3);
    drv(1, 8'hFF, 1, 1, 3);
    check("midRstSticky", sticky, 8'h00);
    check("midRstVld", firstVld, 1'b0);
    check("midRstIdx", firstIdx, 3'd0);
    check("midRstRdV", rdValid, 1'b0);
    check("midRstRdD", rdData, 8'h00);
    check("midRstAlert", alertN, 1'b1);
    drv(0, 8'h00, 0, 1, 3);
    check("midRstCount", rdData, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
